// File: rtl/serial_loader_pkg.sv
// Shared types and helpers for the serial word loader.
// SER_PARITY_EN adds the PAR state (parity bit after the data bits).
package serial_loader_pkg;

  localparam int unsigned STATE_W = 2;

`ifdef SER_PARITY_EN
  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    DONE  = 2'd3
  } state_t;
`else
  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd3
  } state_t;
`endif

  // Bit-count width for an n-bit frame; counts run 0..n-1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bit_counter.sv
// Data-bit counter: clear, increment, and flag on the last bit (N-1).
import serial_loader_pkg::*;

module bit_counter #(
  parameter int unsigned N = 8,
  parameter int unsigned W = cnt_width(N)
) (
  input  logic clk,
  input  logic clear_n,
  input  logic clr,
  input  logic inc,
  output logic term_c
);

  logic [W-1:0] count;

  // Count accepted data bits; clear has priority over increment.
  always_ff @(posedge clk) begin
    if (!clear_n)  count <= '0;
    else if (clr)  count <= '0;
    else if (inc)  count <= count + W'(1);
  end

  assign term_c = (count == W'(N - 1));

endmodule

// File: rtl/serial_loader.sv
// Serial-to-parallel loader: assembles N bits (MSB first) and strobes load.
// SER_PARITY_EN: an even-parity bit follows the data; mismatch sets err.
import serial_loader_pkg::*;

module serial_loader #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         clear_n,
  input  logic         start,
  input  logic         abort,
  input  logic         sin_valid,
  input  logic         sin_bit,
  output logic [N-1:0] word,
  output logic         load,
  output logic         busy,
  output logic         err
);

  state_t       state;
  logic [N-1:0] shreg;
  logic [N-1:0] shift_nxt_c;
  logic         cnt_clr_c;
  logic         cnt_inc_c;
  logic         term_c;

  assign shift_nxt_c = {shreg[N-2:0], sin_bit};
  assign cnt_clr_c   = (state == IDLE) && start;
  assign cnt_inc_c   = (state == SHIFT) && sin_valid && !abort;

  bit_counter #(.N(N)) u_bit_counter (
    .clk     (clk),
    .clear_n (clear_n),
    .clr     (cnt_clr_c),
    .inc     (cnt_inc_c),
    .term_c  (term_c)
  );

`ifdef SER_PARITY_EN
  // Frame FSM with shift register, word register and parity check.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state <= IDLE;
      shreg <= '0;
      word  <= '0;
      load  <= 1'b0;
      busy  <= 1'b0;
      err   <= 1'b0;
    end else begin
      load <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= SHIFT;
            busy  <= 1'b1;
            shreg <= '0;
            err   <= 1'b0;
          end
        end
        SHIFT: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (sin_valid) begin
            shreg <= shift_nxt_c;
            if (term_c) state <= PAR;
          end
        end
        PAR: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (sin_valid) begin
            if (^{shreg, sin_bit} == 1'b0) begin
              word  <= shreg;
              load  <= 1'b1;
              state <= DONE;
            end else begin
              err   <= 1'b1;
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
`else
  // Frame FSM with shift register and word register.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state <= IDLE;
      shreg <= '0;
      word  <= '0;
      load  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      load <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= SHIFT;
            busy  <= 1'b1;
            shreg <= '0;
          end
        end
        SHIFT: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (sin_valid) begin
            shreg <= shift_nxt_c;
            if (term_c) begin
              word  <= shift_nxt_c;
              load  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign err = 1'b0;
`endif

endmodule

// File: doc/serial_loader.md
SERIAL_LOADER -- requirements
Module: serial_loader

Interface
REQ-001 Parameter N, default 8: assembled word width; N >= 2.
REQ-002 clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 clear_n  input  1  reset, synchronous and active-low.
REQ-004 start  input  1  begins a frame when the block is idle.
REQ-005 abort  input  1  cancels the frame in progress.
REQ-006 sin_valid  input  1  sin_bit is valid this cycle.
REQ-007 sin_bit  input  1  serial data, MSB first.
REQ-008 word  output  N  last successfully assembled word; drives the downstream register's in.
REQ-009 load  output  1  one-cycle strobe; drives the downstream register's load.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 err  output  1  parity error flag; tied to 0 when parity is compiled out.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT, PAR and DONE; PAR exists only with SER_PARITY_EN.
REQ-013 IDLE: start=1 -> SHIFT; bit count cleared to 0, shift register cleared to 0.
- sin_valid is ignored in IDLE.
REQ-014 SHIFT: each sin_valid=1 cycle shifts sin_bit into the LSB, shifting earlier bits left, and increments the count.
- sin_valid=0 cycles hold all state; gaps of any length are legal.
REQ-015 The edge that accepts the Nth data bit SHALL go to PAR when parity is enabled, otherwise to DONE.
- Without parity, the same edge loads word with the completed value.
REQ-016 PAR: the first sin_valid=1 cycle samples the parity bit; even parity over N data bits plus the parity bit.
- Match: word <= data; next state DONE.
- Mismatch: err <= 1; word unchanged; no load; next state IDLE.
REQ-017 DONE: load=1 for exactly one cycle, then IDLE unconditionally.
- word already holds the new value while load=1.
- Latency: load rises one cycle after the last accepted bit (data bit, or parity bit when enabled).
REQ-018 start while busy=1 SHALL be ignored.
REQ-019 abort=1 in SHIFT or PAR SHALL force IDLE on the next edge.
- abort takes priority over sin_valid on the same cycle.
- No load pulse; word unchanged; err unchanged.
REQ-020 abort in IDLE or DONE SHALL have no effect; the DONE load pulse still completes.
REQ-021 err SHALL stay set until the next accepted start, which clears it.
REQ-022 word SHALL change only on a successful frame completion.

Reset
REQ-023 clear_n=0 at a rising edge SHALL force IDLE, count=0, shift register=0, word=0, load=0, err=0.
REQ-024 Reset mid-frame SHALL discard the partial frame without a load pulse.
- Reset dominates start, abort and sin_valid on the same cycle.

Configuration
REQ-025 Macro SER_PARITY_EN defined: PAR state and parity check are compiled in.
REQ-026 Macro SER_PARITY_EN undefined: no PAR state; frames are exactly N bits; err is constant 0.

Structure
REQ-027 A shared package serial_loader_pkg SHALL hold:
- the state enum type;
- the state encoding width;
- the count width function/constant, $clog2(N).
REQ-028 The bit counter (clear, increment, terminal-count flag at N-1) SHALL be a sub-module named bit_counter.
- The FSM, shift register and word register remain in serial_loader.

Verification (N=8)
REQ-029 Parity off: start, then bits of 0xA5 on 8 consecutive cycles -> load high exactly one cycle after the 8th bit; word=0xA5 while load=1; busy low the cycle after.
REQ-030 Parity off: 0x3C with 2-cycle sin_valid gaps between bits -> single load pulse, word=0x3C.
- A start pulse mid-frame has no effect.
REQ-031 abort after 3 bits of 0xFF, with sin_valid high the same cycle -> IDLE next cycle; no load; word keeps its prior value (0x3C).
REQ-032 clear_n=0 after 5 bits, then a fresh 0x81 frame -> word=0 right after reset, then word=0x81 with one load pulse.
REQ-033 SER_PARITY_EN: 0xA5 plus parity bit 0 -> load pulse, word=0xA5, err=0.
- 0xA5 plus parity bit 1 -> err=1, no load, word unchanged.
- err clears on the next start.
